// File: rtl/sobel_pkg.sv
// Shared constants and elaboration-time helpers for the streaming Sobel block.
package sobel_pkg;

  localparam logic SOBEL_MAG = 1'b0;
  localparam logic SOBEL_THR = 1'b1;

  // Gradient width: |gx| and |gy| each reach 4*(2^PIX_W-1), and their sum still fits.
  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two-row line store: each write pushes the new pixel into the "mid" row and
// retires the old mid value into the "top" row at the same column.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  localparam int CW = clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [CW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rd_top,
  output logic [PIX_W-1:0] rd_mid
);

  // Upper half holds row r-2, lower half row r-1 relative to the row being written.
  logic [2*PIX_W-1:0] mem [IMG_W];
  logic [2*PIX_W-1:0] rd_word;

  assign rd_word = mem[addr];
  assign rd_top  = rd_word[2*PIX_W-1:PIX_W];
  assign rd_mid  = rd_word[PIX_W-1:0];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= {rd_word[PIX_W-1:0], wdata};
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: line buffers, raster tracking, two-stage
// gradient/output pipeline under a single global advance enable.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             mode,
  input  logic [PIX_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_eol,
  output logic             out_eof
);

  localparam int GW = grad_w(PIX_W);
  localparam int CW = clog2(IMG_W);
  localparam int RW = clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [GW-1:0] SAT_MAX  = {{(GW-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  // Handshake: the whole pipeline advances when the output register is empty
  // or being drained; an input beat transfers on in_valid & in_ready, an output
  // beat on out_valid & out_ready, and out_* are frozen while stalled.
  logic en, accept, launch;
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;

  logic [PIX_W-1:0] rd_top, rd_mid;
  logic [2:0][PIX_W-1:0] top_q, mid_q, bot_q, top_d, mid_d, bot_d;

  logic                 v1_q, eol1_q, eof1_q;
  logic signed [GW-1:0] gx_q, gy_q, gx_d, gy_d;
  logic [GW-1:0]        abs_x, abs_y, sum;
  logic [PIX_W-1:0]     pix_d;

  logic             out_valid_q, out_eol_q, out_eof_q;
  logic [PIX_W-1:0] out_pixel_q;

  assign en       = out_ready | ~out_valid_q;
  assign in_ready = en;
  assign accept   = in_valid & en;

  // A start-of-frame pixel is placed at (0,0) regardless of the running count.
  assign cur_col = in_sof ? '0 : col_q;
  assign cur_row = in_sof ? '0 : row_q;
  assign launch  = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  sobel_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_line_buf (
    .clk    (clk),
    .we     (accept),
    .addr   (cur_col),
    .wdata  (in_pixel),
    .rd_top (rd_top),
    .rd_mid (rd_mid)
  );

  // Index 2 is the newest column; S1 uses the post-shift window so the
  // accepted pixel lands in p8 on the same edge.
  always_comb begin
    top_d = {rd_top,   top_q[2], top_q[1]};
    mid_d = {rd_mid,   mid_q[2], mid_q[1]};
    bot_d = {in_pixel, bot_q[2], bot_q[1]};
  end

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{(GW-PIX_W){1'b0}}, p});
  endfunction

  always_comb begin
    gx_d = (ext(top_d[2]) - ext(top_d[0]))
         + ((ext(mid_d[2]) - ext(mid_d[0])) <<< 1)
         + (ext(bot_d[2]) - ext(bot_d[0]));
    gy_d = (ext(top_d[0]) - ext(bot_d[0]))
         + ((ext(top_d[1]) - ext(bot_d[1])) <<< 1)
         + (ext(top_d[2]) - ext(bot_d[2]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
    end else if (accept) begin
      col_q <= col_d;
      row_q <= row_d;
      top_q <= top_d;
      mid_q <= mid_d;
      bot_q <= bot_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      gx_q   <= '0;
      gy_q   <= '0;
      eol1_q <= 1'b0;
      eof1_q <= 1'b0;
    end else if (en) begin
      v1_q <= launch;
      if (launch) begin
        gx_q   <= gx_d;
        gy_q   <= gy_d;
        eol1_q <= (cur_col == COL_LAST);
        eof1_q <= (cur_col == COL_LAST) && (cur_row == ROW_LAST);
      end
    end
  end

  always_comb begin
    abs_x = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    abs_y = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    sum   = abs_x + abs_y;
    if (mode == SOBEL_THR) begin
      pix_d = (sum >= {{(GW-PIX_W){1'b0}}, thresh}) ? '1 : '0;
    end else begin
      pix_d = (sum > SAT_MAX) ? '1 : sum[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_pixel_q <= '0;
    end else if (en) begin
      out_valid_q <= v1_q;
      out_eol_q   <= v1_q & eol1_q;
      out_eof_q   <= v1_q & eof1_q;
      if (v1_q) out_pixel_q <= pix_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream on an 8x6 image: image-level reference model feeding
// an expected queue, one compare process on the output port, literal pins.
module tb_sobel_stream;

  localparam int PIX_W = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;

  logic             clk, rst_n;
  logic             in_valid, in_ready, in_sof;
  logic [PIX_W-1:0] in_pixel;
  logic             mode;
  logic [PIX_W-1:0] thresh;
  logic             out_valid, out_ready, out_eol, out_eof;
  logic [PIX_W-1:0] out_pixel;

  sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .mode      (mode),
    .thresh    (thresh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int img [IMG_H][IMG_W];
  logic [9:0] exp_q [$];
  logic [7:0] got_q [$];
  int n_out, n_eol, n_eof;
  int rdy_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 held low by main

  task automatic report();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Output for centre (r,c) of the current image: {eol, eof, pixel}.
  function automatic logic [9:0] model(input int r, input int c);
    int gx, gy, s;
    logic [7:0] px;
    gx = (img[r-1][c+1] - img[r-1][c-1]) + 2 * (img[r][c+1] - img[r][c-1])
       + (img[r+1][c+1] - img[r+1][c-1]);
    gy = (img[r-1][c-1] - img[r+1][c-1]) + 2 * (img[r-1][c] - img[r+1][c])
       + (img[r-1][c+1] - img[r+1][c+1]);
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mode) px = (s >= int'(thresh)) ? 8'hFF : 8'h00;
    else      px = (s > 255) ? 8'hFF : 8'(s);
    return {(c == IMG_W - 2), (c == IMG_W - 2) && (r == IMG_H - 2), px};
  endfunction

  task automatic fill(input int kind);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        case (kind)
          0:       img[r][c] = 100;
          1:       img[r][c] = (c >= 4) ? 255 : 0;
          2:       img[r][c] = c * 10;
          default: img[r][c] = int'($urandom_range(255));
        endcase
  endtask

  // ---------------- drivers ----------------
  task automatic send_frame(input int npix, input int gap_pct);
    for (int i = 0; i < npix; i++) begin
      int r, c, waitc;
      r = i / IMG_W;
      c = i % IMG_W;
      waitc = 0;
      @(negedge clk);
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_pixel = img[r][c][7:0];
      #4;
      while (!in_ready) begin
        waitc++;
        if (waitc > 1000) begin
          checks++;
          errors++;
          $display("FAIL in_ready_timeout: pixel %0d still not accepted", i);
          report();
        end
        @(negedge clk);
        #4;
      end
      @(posedge clk);
      if (r >= 2 && c >= 2) exp_q.push_back(model(r - 1, c - 1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  always @(negedge clk) begin
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = ($urandom_range(99) < 60);
      default: ;
    endcase
  end

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_stats();
    n_out = 0;
    n_eol = 0;
    n_eof = 0;
    got_q.delete();
  endtask

  task automatic frame_counts(input string tag, input int e_out, input int e_eol, input int e_eof);
    check({tag, "_n_out"}, n_out, e_out);
    check({tag, "_n_eol"}, n_eol, e_eol);
    check({tag, "_n_eof"}, n_eof, e_eof);
  endtask

  task automatic all_equal(input string tag, input logic [7:0] v);
    int bad;
    bad = 0;
    foreach (got_q[i]) if (got_q[i] !== v) bad++;
    check(tag, bad, 0);
  endtask

  // ---------------- scoreboard / compare process ----------------
  initial begin
    logic       stall_prev;
    logic [10:0] held;
    logic [9:0] e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        check("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (stall_prev) check("stall_hold", {out_valid, out_eol, out_eof, out_pixel}, held);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", {out_eol, out_eof, out_pixel}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("out_word", {out_eol, out_eof, out_pixel}, e);
          end
          n_out++;
          n_eol += int'(out_eol);
          n_eof += int'(out_eof);
          got_q.push_back(out_pixel);
        end
        stall_prev = out_valid && !out_ready;
        held = {out_valid, out_eol, out_eof, out_pixel};
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    mode = 1'b0; thresh = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #4;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_flags", {out_eol, out_eof}, 0);

    // Literal pins on the reference model itself.
    fill(0);
    check("pin_flat", model(2, 3), 10'h000);
    fill(1);
    check("pin_vedge_c3", model(2, 3), 10'h0FF);
    check("pin_vedge_c2", model(2, 2), 10'h000);
    check("pin_vedge_c4", model(3, 4), 10'h0FF);
    check("pin_vedge_c5", model(3, 5), 10'h000);
    check("pin_eol", model(1, 6), {2'b10, 8'h00});
    check("pin_eof", model(4, 6), {2'b11, 8'h00});
    fill(2);
    check("pin_ramp", model(3, 3), 10'd80);
    mode = 1'b1; thresh = 8'd80;
    check("pin_thr80", model(3, 3), 10'h0FF);
    thresh = 8'd81;
    check("pin_thr81", model(3, 3), 10'h000);
    mode = 1'b0;

    // Flat frame.
    clear_stats(); fill(0); send_frame(48, 0); drain();
    frame_counts("flat", 24, 4, 1);
    all_equal("flat_all0", 8'd0);

    // Vertical edge.
    clear_stats(); fill(1); send_frame(48, 20); drain();
    frame_counts("vedge", 24, 4, 1);
    begin
      int bad;
      bad = 0;
      foreach (got_q[i]) begin
        int c;
        c = (i % 6) + 1;
        if (got_q[i] !== ((c == 3 || c == 4) ? 8'd255 : 8'd0)) bad++;
      end
      check("vedge_pattern", bad, 0);
    end

    // Ramp in both modes.
    clear_stats(); fill(2); send_frame(48, 0); drain();
    frame_counts("ramp", 24, 4, 1);
    all_equal("ramp_all80", 8'd80);
    mode = 1'b1; thresh = 8'd80;
    clear_stats(); send_frame(48, 0); drain();
    all_equal("ramp_thr80", 8'd255);
    thresh = 8'd81;
    clear_stats(); send_frame(48, 0); drain();
    all_equal("ramp_thr81", 8'd0);
    mode = 1'b0;

    // Backpressure: toggling out_ready, random input gaps.
    rdy_mode = 1;
    clear_stats(); send_frame(48, 30); drain();
    frame_counts("bp", 24, 4, 1);
    all_equal("bp_all80", 8'd80);

    // Back-to-back random frames with in_sof at pixel 20 of the second.
    rdy_mode = 2;
    clear_stats();
    fill(3); send_frame(48, 25);
    fill(3); send_frame(20, 25);
    fill(3); send_frame(48, 25);
    drain();
    frame_counts("b2b", 50, 8, 2);

    // Random threshold mode.
    mode = 1'b1; thresh = 8'($urandom_range(40, 400 > 255 ? 255 : 400));
    clear_stats(); fill(3); send_frame(48, 25); drain();
    frame_counts("rand_thr", 24, 4, 1);
    mode = 1'b0;

    // Asynchronous reset pulse while an output is held.
    clear_stats(); fill(3); send_frame(21, 10);
    rdy_mode = 3;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    check("pre_reset_valid", out_valid, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_pixel", {out_eol, out_eof, out_pixel}, 0);
    #5;
    rst_n = 1'b1;
    rdy_mode = 0;
    clear_stats(); fill(3); send_frame(48, 15); drain();
    frame_counts("post_rst", 24, 4, 1);

    report();
  end

endmodule
